run_step_controller: RTL and testbench
======================================

// Module: run_step_controller
// PURPOSE
//  Parametrised run/step controller for the 16-bit core, replacing the single-button
//  debounce that clocks the core directly. The core is clocked by clk; this block
//  emits core_en. It supports debounced single/N-step, free-run, a PC breakpoint and
//  an instruction counter.
// PARAMETERS
//  DEBOUNCE_CYCLES  100000  cycles a button must stay high before its pulse fires
//  PC_W             16      width of pc and bp_addr
//  CNT_W            16      width of step_n, the remaining-step counter and instr_count
//  PRESCALE_LOG2    4       run-mode issue period is 2**PRESCALE_LOG2 (CPU_RUN_PRESCALE_EN only)
// PORTS
//  clk          in   1      system clock; all state on posedge
//  clr          in   1      asynchronous reset, active low
//  btn_step     in   1      raw step button, async to clk, active high
//  btn_run      in   1      raw run/stop toggle button, active high
//  step_n       in   CNT_W  steps per step press; 0 is treated as 1
//  bp_en        in   1      breakpoint enable
//  bp_addr      in   PC_W   breakpoint PC
//  pc           in   PC_W   current core PC (core updates it on the clk edge where core_en=1)
//  core_en      out  1      core advances one instruction on each clk edge where this is 1
//  running      out  1      1 while in RUN
//  halted_bp    out  1      1 while in BREAK
//  instr_count  out  CNT_W  number of core_en cycles issued, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE; debounce counters, remaining, instr_count, skip_bp=0;
//   core_en, running and halted_bp go to 0 immediately.
//  Debounce: each button has a 2-FF synchroniser and a counter. While the synchronised
//   input is 1, the counter increments and saturates at DEBOUNCE_CYCLES+1. On the cycle
//   it equals DEBOUNCE_CYCLES, a 1-cycle pulse is produced. While the input is 0, the
//   counter is 0. One pulse per press; a glitch shorter than DEBOUNCE_CYCLES gives none.
//  bp_hit = bp_en && (pc == bp_addr).
//  tick = 1 every cycle, except when noted under CONFIGURATION.
//  core_en is combinational from registered state plus pc/bp inputs only:
//   core_en = ((state==STEP) || (state==RUN && tick)) && !(bp_hit && !skip_bp).
//  skip_bp: set when entering STEP or RUN from IDLE or BREAK. Cleared after the first
//   core_en. This lets the core step off a breakpoint it is sitting on.
//  States:
//   IDLE : run_p -> RUN. step_p -> STEP with remaining = (step_n==0 ? 1 : step_n).
//   STEP : remaining decrements on each core_en; core_en with remaining==1 -> IDLE.
//          bp_hit && !skip_bp -> BREAK, no pulse issued. run_p -> RUN, abandoning
//          remaining steps. step_p is ignored.
//   RUN  : bp_hit && !skip_bp -> BREAK. run_p -> IDLE, stop. step_p is ignored.
//   BREAK: same exits as IDLE. halted_bp=1. Clearing bp_en does not leave BREAK.
//  If run_p and step_p fire in the same cycle, run_p wins.
//  A run_p arriving in the same cycle as a breakpoint stop in RUN gives IDLE (stop wins).
//  instr_count increments on every core_en and wraps from all-ones to 0.
//  Latency: step press to first core_en is DEBOUNCE_CYCLES + 3 clk cycles
//   (2 synchroniser, 1 state register).
//  running = (state==RUN); halted_bp = (state==BREAK). Both are registered decodes.
// CONFIGURATION
//  CPU_RUN_PRESCALE_EN defined:
//   - A PRESCALE_LOG2-bit free counter runs while in RUN and is cleared on entry to RUN.
//   - tick = (counter == 0), so RUN issues one instruction per 2**PRESCALE_LOG2 cycles.
//   - The first pulse comes on the entry cycle. STEP is unaffected.
//  CPU_RUN_PRESCALE_EN undefined:
//   - tick is tied to 1 and no counter logic is built.
//   - PRESCALE_LOG2 is ignored.
// TESTING  (DEBOUNCE_CYCLES=4 in bench)
//  btn_step high 3 cycles, then low -> no core_en, state stays IDLE.
//  step_n=3, btn_step held 10 cycles -> exactly 3 consecutive core_en cycles,
//   instr_count=3, then IDLE.
//  step_n=0, one press -> exactly 1 core_en.
//  bp_en=1, bp_addr=0x0005, bench core increments pc from 0, run press ->
//   core_en for pc 0..4 (5 pulses); at pc=5, core_en=0 and halted_bp=1.
//  From that BREAK, step press with step_n=1 -> 1 core_en (pc 5->6), state IDLE.
//   Then a run press runs until pc wraps to 5 again.
//  clr low mid-RUN with instr_count=7 -> same cycle: core_en=0, running=0; after
//   release: instr_count=0, state IDLE.
//  CPU_RUN_PRESCALE_EN with PRESCALE_LOG2=2, run for 16 cycles -> 4 core_en pulses,
//   spaced 4 cycles apart.

Source files
------------

// File: rtl/run_step_controller.sv
// Run/step controller for the 16-bit core: debounced step/N-step, free-run, PC breakpoint, instruction counter.
// Optional CPU_RUN_PRESCALE_EN: RUN issues one instruction per 2**PRESCALE_LOG2 cycles.
module run_step_controller #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int PC_W            = 16,
   parameter int CNT_W           = 16,
   parameter int PRESCALE_LOG2   = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             btn_step,
   input  logic             btn_run,
   input  logic [CNT_W-1:0] step_n,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   output logic             core_en,
   output logic             running,
   output logic             halted_bp,
   output logic [CNT_W-1:0] instr_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [DB_W-1:0]  DB_FIRE = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]  DB_SAT  = DB_W'(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP  = 2'd1,
      S_RUN   = 2'd2,
      S_BREAK = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
   logic [DB_W-1:0]  step_cnt_q, step_cnt_d, run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             skip_bp_q, skip_bp_d;
   logic             running_q, running_d;
   logic             halted_bp_q, halted_bp_d;

   logic step_p_s, run_p_s, bp_hit_s, bp_stop_s, tick_s, core_en_s;

   // Saturating press counter: counts while held, zero while released.
   function automatic logic [DB_W-1:0] db_next(input logic in_s, input logic [DB_W-1:0] cnt);
      if (!in_s) begin
         return {DB_W{1'b0}};
      end else if (cnt == DB_SAT) begin
         return cnt;
      end else begin
         return cnt + DB_ONE;
      end
   endfunction

   // Synchronisers and debounce counters; bit 0 is step, bit 1 is run.
   always_comb begin
      sync1_d    = {btn_run, btn_step};
      sync2_d    = sync1_q;
      step_cnt_d = db_next(sync2_q[0], step_cnt_q);
      run_cnt_d  = db_next(sync2_q[1], run_cnt_q);
   end

   assign step_p_s  = (step_cnt_q == DB_FIRE);
   assign run_p_s   = (run_cnt_q == DB_FIRE);
   assign bp_hit_s  = bp_en && (pc == bp_addr);
   assign bp_stop_s = bp_hit_s && !skip_bp_q;

`ifdef CPU_RUN_PRESCALE_EN
   localparam logic [PRESCALE_LOG2-1:0] PRESC_ONE = {{(PRESCALE_LOG2-1){1'b0}}, 1'b1};
   logic [PRESCALE_LOG2-1:0] presc_q, presc_d;

   // Free-running issue divider, restarted on every entry into RUN.
   always_comb begin
      if ((state_q == S_RUN) && (state_d == S_RUN)) begin
         presc_d = presc_q + PRESC_ONE;
      end else begin
         presc_d = {PRESCALE_LOG2{1'b0}};
      end
   end

   // Divider register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         presc_q <= {PRESCALE_LOG2{1'b0}};
      end else begin
         presc_q <= presc_d;
      end
   end

   assign tick_s = (presc_q == {PRESCALE_LOG2{1'b0}});
`else
   assign tick_s = 1'b1;
`endif

   assign core_en_s = ((state_q == S_STEP) || ((state_q == S_RUN) && tick_s)) && !bp_stop_s;

   // Next-state, step bookkeeping and instruction counter.
   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      skip_bp_d     = skip_bp_q;
      instr_count_d = instr_count_q;

      if (core_en_s) begin
         skip_bp_d     = 1'b0;
         instr_count_d = instr_count_q + CNT_ONE;
      end else begin
         instr_count_d = instr_count_q;
      end

      case (state_q)
         S_IDLE, S_BREAK: begin
            if (run_p_s) begin
               state_d   = S_RUN;
               skip_bp_d = 1'b1;
            end else if (step_p_s) begin
               state_d     = S_STEP;
               skip_bp_d   = 1'b1;
               remaining_d = (step_n == {CNT_W{1'b0}}) ? CNT_ONE : step_n;
            end else begin
               state_d = state_q;
            end
         end
         S_STEP: begin
            if (run_p_s) begin
               state_d = S_RUN;
            end else if (bp_stop_s) begin
               state_d = S_BREAK;
            end else if (core_en_s) begin
               remaining_d = remaining_q - CNT_ONE;
               state_d     = (remaining_q == CNT_ONE) ? S_IDLE : S_STEP;
            end else begin
               state_d = S_STEP;
            end
         end
         S_RUN: begin
            // A stop request beats a simultaneous breakpoint.
            if (run_p_s) begin
               state_d = S_IDLE;
            end else if (bp_stop_s) begin
               state_d = S_BREAK;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      running_d   = (state_d == S_RUN);
      halted_bp_d = (state_d == S_BREAK);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q       <= S_IDLE;
         sync1_q       <= 2'b00;
         sync2_q       <= 2'b00;
         step_cnt_q    <= {DB_W{1'b0}};
         run_cnt_q     <= {DB_W{1'b0}};
         remaining_q   <= {CNT_W{1'b0}};
         instr_count_q <= {CNT_W{1'b0}};
         skip_bp_q     <= 1'b0;
         running_q     <= 1'b0;
         halted_bp_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         step_cnt_q    <= step_cnt_d;
         run_cnt_q     <= run_cnt_d;
         remaining_q   <= remaining_d;
         instr_count_q <= instr_count_d;
         skip_bp_q     <= skip_bp_d;
         running_q     <= running_d;
         halted_bp_q   <= halted_bp_d;
      end
   end

   assign core_en     = core_en_s;
   assign running     = running_q;
   assign halted_bp   = halted_bp_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_run_step_controller.sv
// Scoreboard bench for run_step_controller: expected core PCs are queued at stimulus
// time and matched against the PCs seen on core_en pulses.
module tb_run_step_controller;

   localparam int D     = 4;
   localparam int PC_W  = 8;
   localparam int CNT_W = 8;
`ifdef CPU_RUN_PRESCALE_EN
   localparam int SP = 4;
`else
   localparam int SP = 1;
`endif

   logic             clk = 1'b0;
   logic             clr = 1'b1;
   logic             btn_step = 1'b0;
   logic             btn_run = 1'b0;
   logic             bp_en = 1'b0;
   logic [CNT_W-1:0] step_n = '0;
   logic [PC_W-1:0]  bp_addr = '0;
   logic [PC_W-1:0]  pc;
   logic             core_en, running, halted_bp;
   logic [CNT_W-1:0] instr_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int obs_rd = 0;
   logic [PC_W-1:0] exp_q[$];
   logic [PC_W-1:0] obs_q[$];
   int              obs_t[$];

   run_step_controller #(
      .DEBOUNCE_CYCLES(D), .PC_W(PC_W), .CNT_W(CNT_W), .PRESCALE_LOG2(2)
   ) dut (
      .clk(clk), .clr(clr), .btn_step(btn_step), .btn_run(btn_run),
      .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .core_en(core_en), .running(running), .halted_bp(halted_bp),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bench core: PC advances on every enabled edge.
   always @(posedge clk or negedge clr) begin
      if (!clr) pc <= '0;
      else if (core_en) pc <= pc + 1'b1;
   end

   always @(negedge clk) begin
      if (core_en === 1'b1) begin
         obs_q.push_back(pc);
         obs_t.push_back(cyc);
      end
   end

   task automatic press(input logic s, input logic r, input int hold, output int t);
      @(negedge clk);
      t = cyc;
      btn_step = s;
      btn_run = r;
      repeat (hold) @(negedge clk);
      btn_step = 1'b0;
      btn_run = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      obs_rd = obs_q.size();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 clr = 1'b0;
      #1;
      checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b, expected 0", core_en); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b, expected 0", running); end
      checks++; if (halted_bp !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b, expected 0", halted_bp); end
      checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", instr_count); end
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_glitch();
      int t;
      press(1'b1, 1'b0, 3, t);
      repeat (12) @(negedge clk);
      checks++; if (obs_q.size() != obs_rd) begin errors++; $display("FAIL glitch_pulses: got %0d, expected 0", obs_q.size() - obs_rd); end
      checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL glitch_count: got %0d, expected 0", instr_count); end
   endtask

   task automatic test_step_n();
      int t, base;
      logic [PC_W-1:0] e;
      base = obs_rd;
      step_n = 8'd3;
      for (int i = 0; i < 3; i++) exp_q.push_back(PC_W'(i));
      press(1'b1, 1'b0, 10, t);
      repeat (10) @(negedge clk);
      checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin errors++; $display("FAIL step3_count: got %0d pulses, expected %0d", obs_q.size() - obs_rd, exp_q.size()); end
      if (obs_q.size() > base) begin
         checks++; if (obs_t[base] != t + D + 3) begin errors++; $display("FAIL step3_latency: got %0d cycles, expected %0d", obs_t[base] - t, D + 3); end
      end
      for (int i = base + 1; i < obs_q.size(); i++) begin
         checks++; if (obs_t[i] - obs_t[i-1] != 1) begin errors++; $display("FAIL step3_consecutive: gap %0d, expected 1", obs_t[i] - obs_t[i-1]); end
      end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
         e = exp_q.pop_front();
         checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL step3_pc: got %0h, expected %0h", obs_q[obs_rd], e); end
         obs_rd++;
      end
      exp_q.delete(); obs_rd = obs_q.size();
      checks++; if (instr_count !== 8'd3) begin errors++; $display("FAIL step3_instr: got %0d, expected 3", instr_count); end
      checks++; if (running !== 1'b0 || halted_bp !== 1'b0) begin errors++; $display("FAIL step3_idle: got running=%b halted=%b, expected 0 0", running, halted_bp); end
   endtask

   task automatic test_step_zero();
      int t;
      logic [PC_W-1:0] e;
      step_n = 8'd0;
      exp_q.push_back(8'd3);
      press(1'b1, 1'b0, 10, t);
      repeat (10) @(negedge clk);
      checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin errors++; $display("FAIL step0_count: got %0d pulses, expected %0d", obs_q.size() - obs_rd, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
         e = exp_q.pop_front();
         checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL step0_pc: got %0h, expected %0h", obs_q[obs_rd], e); end
         obs_rd++;
      end
      exp_q.delete(); obs_rd = obs_q.size();
      checks++; if (instr_count !== 8'd4) begin errors++; $display("FAIL step0_instr: got %0d, expected 4", instr_count); end
   endtask

   task automatic test_breakpoint();
      int t, n;
      logic [PC_W-1:0] e;
      do_reset();
      bp_en = 1'b1;
      bp_addr = 8'h05;
      for (int i = 0; i < 5; i++) exp_q.push_back(PC_W'(i));
      press(1'b0, 1'b1, 8, t);
      n = 0;
      while (halted_bp !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++; if (halted_bp !== 1'b1) begin errors++; $display("FAIL bp_halt: got %b, expected 1", halted_bp); end
      repeat (3 * SP) @(negedge clk);
      checks++; if (core_en !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL bp_stopped: got core_en=%b running=%b, expected 0 0", core_en, running); end
      checks++; if (pc !== 8'h05) begin errors++; $display("FAIL bp_pc: got %0h, expected 5", pc); end
      checks++; if (instr_count !== 8'd5) begin errors++; $display("FAIL bp_instr: got %0d, expected 5", instr_count); end
      checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d pulses, expected %0d", obs_q.size() - obs_rd, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
         e = exp_q.pop_front();
         checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL bp_pc_seq: got %0h, expected %0h", obs_q[obs_rd], e); end
         obs_rd++;
      end
      exp_q.delete(); obs_rd = obs_q.size();
      bp_en = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (halted_bp !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b, expected 1", halted_bp); end
      bp_en = 1'b1;
   endtask

   task automatic test_step_off_bp();
      int t, n;
      logic [PC_W-1:0] e;
      step_n = 8'd1;
      exp_q.push_back(8'h05);
      press(1'b1, 1'b0, 10, t);
      repeat (6) @(negedge clk);
      checks++; if (halted_bp !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL stepoff_idle: got halted=%b running=%b, expected 0 0", halted_bp, running); end
      checks++; if (pc !== 8'h06) begin errors++; $display("FAIL stepoff_pc: got %0h, expected 6", pc); end
      for (int i = 6; i < 256; i++) exp_q.push_back(PC_W'(i));
      for (int i = 0; i < 5; i++) exp_q.push_back(PC_W'(i));
      press(1'b0, 1'b1, 8, t);
      n = 0;
      while (halted_bp !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      checks++; if (halted_bp !== 1'b1) begin errors++; $display("FAIL wrap_halt: got %b, expected 1", halted_bp); end
      repeat (4) @(negedge clk);
      checks++; if (obs_q.size() - obs_rd != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d pulses, expected %0d", obs_q.size() - obs_rd, exp_q.size()); end
      while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
         e = exp_q.pop_front();
         checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL wrap_pc_seq: got %0h, expected %0h", obs_q[obs_rd], e); end
         obs_rd++;
      end
      exp_q.delete(); obs_rd = obs_q.size();
      checks++; if (pc !== 8'h05) begin errors++; $display("FAIL wrap_pc: got %0h, expected 5", pc); end
      checks++; if (instr_count !== 8'd5) begin errors++; $display("FAIL wrap_instr: got %0d, expected 5", instr_count); end
   endtask

   task automatic test_clr_mid_run();
      int t, n;
      bp_en = 1'b0;
      do_reset();
      press(1'b0, 1'b1, 8, t);
      n = 0;
      while (instr_count !== 8'd7 && n < 500) @(negedge clk) n++;
      checks++; if (instr_count !== 8'd7 || running !== 1'b1) begin errors++; $display("FAIL clr_pre: got count=%0d running=%b, expected 7 1", instr_count, running); end
      clr = 1'b0;
      #1;
      checks++; if (core_en !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL clr_async: got core_en=%b running=%b, expected 0 0", core_en, running); end
      repeat (2) @(negedge clk);
      clr = 1'b1;
      obs_rd = obs_q.size();
      @(negedge clk);
      checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL clr_count: got %0d, expected 0", instr_count); end
      repeat (12) @(negedge clk);
      checks++; if (obs_q.size() != obs_rd || running !== 1'b0) begin errors++; $display("FAIL clr_idle: got %0d pulses running=%b, expected 0 0", obs_q.size() - obs_rd, running); end
   endtask

   task automatic test_back_to_back();
      int t, base, w, sz;
      do_reset();
      step_n = 8'd0;
      base = obs_rd;
      press(1'b1, 1'b1, 8, t);
      repeat (32) @(negedge clk);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL both_run_wins: got %b, expected 1", running); end
      checks++; if (obs_q.size() - base < 4) begin errors++; $display("FAIL run_pulses: got %0d, expected at least 4", obs_q.size() - base); end
      if (obs_q.size() - base >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (obs_q[base+i] !== PC_W'(i)) begin errors++; $display("FAIL run_pc_seq: got %0h, expected %0h", obs_q[base+i], i); end
         end
         for (int i = 1; i < 4; i++) begin
            checks++; if (obs_t[base+i] - obs_t[base+i-1] != SP) begin errors++; $display("FAIL run_spacing: got %0d, expected %0d", obs_t[base+i] - obs_t[base+i-1], SP); end
         end
         w = 0;
         for (int i = base; i < obs_q.size(); i++) if (obs_t[i] < obs_t[base] + 16) w++;
         checks++; if (w != 16 / SP) begin errors++; $display("FAIL run_window: got %0d pulses in 16 cycles, expected %0d", w, 16 / SP); end
      end
      press(1'b0, 1'b1, 8, t);
      repeat (10) @(negedge clk);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_stop: got %b, expected 0", running); end
      checks++; if (instr_count !== pc) begin errors++; $display("FAIL run_instr: got %0d, expected %0d", instr_count, pc); end
      sz = obs_q.size();
      repeat (10) @(negedge clk);
      checks++; if (obs_q.size() != sz) begin errors++; $display("FAIL run_stopped_pulses: got %0d, expected 0", obs_q.size() - sz); end
      obs_rd = obs_q.size();
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_step_n();
      test_step_zero();
      test_breakpoint();
      test_step_off_bp();
      test_clr_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
